// File: rtl/conv_seq.sv
// Convolution MAC sequencer: walks every output pixel of a stride-1 convolution and
// drives feature/weight/bias read addresses plus MAC strobes. Optional CONV_SEQ_PERF_EN adds a busy-cycle counter.
module conv_seq #(
    parameter int DATA_SIZE = 16,
    parameter int MEM_SIZE  = 16,
    parameter int DIM_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hold,
    input  logic [DIM_W-1:0]    cfg_in_w,
    input  logic [DIM_W-1:0]    cfg_in_h,
    input  logic [DIM_W-1:0]    cfg_in_c,
    input  logic [DIM_W-1:0]    cfg_out_c,
    input  logic [3:0]          cfg_k,
    input  logic [MEM_SIZE-1:0] cfg_in_base,
    input  logic [MEM_SIZE-1:0] cfg_w_base,
    input  logic [MEM_SIZE-1:0] cfg_b_base,
    input  logic [MEM_SIZE-1:0] cfg_out_base,
    output logic [MEM_SIZE-1:0] in_ra,
    output logic [MEM_SIZE-1:0] w_ra,
    output logic [MEM_SIZE-1:0] b_ra,
    output logic                mac_en,
    output logic                mac_set_b,
    output logic [MEM_SIZE-1:0] mac_wa,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         perf_cycles
);

    if (DATA_SIZE < 1) begin : g_param_check
        $error("conv_seq: DATA_SIZE must be positive");
    end

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

    state_t              state_reg, state_next;

    logic [DIM_W-1:0]    in_w_reg, in_h_reg, in_c_reg, out_c_reg;
    logic [3:0]          k_reg;
    logic [MEM_SIZE-1:0] in_base_reg, w_base_reg, b_base_reg, out_base_reg;

    logic [DIM_W-1:0]    oc_reg, oy_reg, ox_reg, ic_reg;
    logic [3:0]          ky_reg, kx_reg;
    logic                bias_reg;
    logic [1:0]          drain_reg;
    logic                err_reg;
    logic                mac_en_reg, mac_set_b_reg;
    logic [MEM_SIZE-1:0] mac_wa_reg;

    logic                illegal, issue, run_st;
    logic                last_kx, last_ky, last_ic, last_ox, last_oy, last_oc, last_slot;
    logic [DIM_W-1:0]    k_dim, ow_dim, oh_dim;
    logic [MEM_SIZE-1:0] m_ic, m_oc, m_oy, m_ox, m_ky, m_kx, m_k;
    logic [MEM_SIZE-1:0] m_in_w, m_in_h, m_in_c, m_ow, m_oh;
    logic [MEM_SIZE-1:0] in_addr, w_addr, b_addr, wa_addr;

    assign k_dim   = DIM_W'(k_reg);
    assign ow_dim  = in_w_reg - k_dim + DIM_W'(1);
    assign oh_dim  = in_h_reg - k_dim + DIM_W'(1);

    assign illegal = (k_reg == 4'd0) || (k_dim > in_w_reg) || (k_dim > in_h_reg) ||
                     (in_c_reg == '0) || (out_c_reg == '0);

    assign run_st  = (state_reg == RUN);
    assign issue   = run_st && !hold;

    assign last_kx   = (kx_reg == k_reg - 4'd1);
    assign last_ky   = (ky_reg == k_reg - 4'd1);
    assign last_ic   = (ic_reg == in_c_reg - DIM_W'(1));
    assign last_ox   = (ox_reg == in_w_reg - k_dim);
    assign last_oy   = (oy_reg == in_h_reg - k_dim);
    assign last_oc   = (oc_reg == out_c_reg - DIM_W'(1));
    assign last_slot = bias_reg && last_ox && last_oy && last_oc;

    // All address arithmetic is done at MEM_SIZE width; low product bits give the required modulo result.
    assign m_ic   = MEM_SIZE'(ic_reg);
    assign m_oc   = MEM_SIZE'(oc_reg);
    assign m_oy   = MEM_SIZE'(oy_reg);
    assign m_ox   = MEM_SIZE'(ox_reg);
    assign m_ky   = MEM_SIZE'(ky_reg);
    assign m_kx   = MEM_SIZE'(kx_reg);
    assign m_k    = MEM_SIZE'(k_reg);
    assign m_in_w = MEM_SIZE'(in_w_reg);
    assign m_in_h = MEM_SIZE'(in_h_reg);
    assign m_in_c = MEM_SIZE'(in_c_reg);
    assign m_ow   = MEM_SIZE'(ow_dim);
    assign m_oh   = MEM_SIZE'(oh_dim);

    assign in_addr = in_base_reg + (m_ic * m_in_h + m_oy + m_ky) * m_in_w + m_ox + m_kx;
    assign w_addr  = w_base_reg + ((m_oc * m_in_c + m_ic) * m_k + m_ky) * m_k + m_kx;
    assign b_addr  = b_base_reg + m_oc;
    assign wa_addr = out_base_reg + (m_oc * m_oh + m_oy) * m_ow + m_ox;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = illegal ? DONE : RUN;
            RUN:     if (issue && last_slot) state_next = DRAIN;
            DRAIN:   if (drain_reg == 2'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_w_reg      <= '0;
            in_h_reg      <= '0;
            in_c_reg      <= '0;
            out_c_reg     <= '0;
            k_reg         <= '0;
            in_base_reg   <= '0;
            w_base_reg    <= '0;
            b_base_reg    <= '0;
            out_base_reg  <= '0;
            oc_reg        <= '0;
            oy_reg        <= '0;
            ox_reg        <= '0;
            ic_reg        <= '0;
            ky_reg        <= '0;
            kx_reg        <= '0;
            bias_reg      <= 1'b0;
            drain_reg     <= '0;
            err_reg       <= 1'b0;
            mac_en_reg    <= 1'b0;
            mac_set_b_reg <= 1'b0;
            mac_wa_reg    <= '0;
        end else begin
            mac_en_reg    <= issue;
            mac_set_b_reg <= issue && bias_reg;
            if (issue) begin
                mac_wa_reg <= wa_addr;
            end

            case (state_reg)
                IDLE: begin
                    // The descriptor is captured at launch so the control FSM may change it mid-run.
                    if (start) begin
                        in_w_reg     <= cfg_in_w;
                        in_h_reg     <= cfg_in_h;
                        in_c_reg     <= cfg_in_c;
                        out_c_reg    <= cfg_out_c;
                        k_reg        <= cfg_k;
                        in_base_reg  <= cfg_in_base;
                        w_base_reg   <= cfg_w_base;
                        b_base_reg   <= cfg_b_base;
                        out_base_reg <= cfg_out_base;
                        err_reg      <= 1'b0;
                    end
                end
                CHECK: begin
                    oc_reg    <= '0;
                    oy_reg    <= '0;
                    ox_reg    <= '0;
                    ic_reg    <= '0;
                    ky_reg    <= '0;
                    kx_reg    <= '0;
                    bias_reg  <= 1'b0;
                    drain_reg <= '0;
                    err_reg   <= illegal;
                end
                RUN: begin
                    if (issue) begin
                        if (bias_reg) begin
                            bias_reg <= 1'b0;
                            if (last_ox) begin
                                ox_reg <= '0;
                                if (last_oy) begin
                                    oy_reg <= '0;
                                    oc_reg <= oc_reg + DIM_W'(1);
                                end else begin
                                    oy_reg <= oy_reg + DIM_W'(1);
                                end
                            end else begin
                                ox_reg <= ox_reg + DIM_W'(1);
                            end
                        end else if (last_kx) begin
                            kx_reg <= '0;
                            if (last_ky) begin
                                ky_reg <= '0;
                                if (last_ic) begin
                                    ic_reg   <= '0;
                                    bias_reg <= 1'b1;
                                end else begin
                                    ic_reg <= ic_reg + DIM_W'(1);
                                end
                            end else begin
                                ky_reg <= ky_reg + 4'd1;
                            end
                        end else begin
                            kx_reg <= kx_reg + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    drain_reg <= drain_reg + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ra     = run_st ? in_addr : '0;
    assign w_ra      = run_st ? w_addr  : '0;
    assign b_ra      = run_st ? b_addr  : '0;
    assign mac_en    = mac_en_reg;
    assign mac_set_b = mac_set_b_reg;
    assign mac_wa    = mac_wa_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign err       = err_reg;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (start) perf_reg <= '0;
        end else begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_seq.sv
// Directed bench for conv_seq: a descriptor table with hand-computed timing plus
// an address-sequence model, and hand sequences for reset behaviour.
module tb_conv_seq;

`ifdef CONV_SEQ_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk, rst, start, hold;
    logic [7:0]  cfg_in_w, cfg_in_h, cfg_in_c, cfg_out_c;
    logic [3:0]  cfg_k;
    logic [15:0] cfg_in_base, cfg_w_base, cfg_b_base, cfg_out_base;
    logic [15:0] in_ra, w_ra, b_ra, mac_wa;
    logic        mac_en, mac_set_b, busy, done, err;
    logic [31:0] perf_cycles;

    conv_seq #(.DATA_SIZE(16), .MEM_SIZE(16), .DIM_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_in_c(cfg_in_c), .cfg_out_c(cfg_out_c),
        .cfg_k(cfg_k), .cfg_in_base(cfg_in_base), .cfg_w_base(cfg_w_base),
        .cfg_b_base(cfg_b_base), .cfg_out_base(cfg_out_base),
        .in_ra(in_ra), .w_ra(w_ra), .b_ra(b_ra), .mac_en(mac_en), .mac_set_b(mac_set_b),
        .mac_wa(mac_wa), .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
    );

    typedef struct {
        int in_w, in_h, in_c, out_c, k;
        int in_b, w_b, b_b, o_b;
        int hold_at, hold_len, restart_at;
        int exp_done, exp_en, exp_err;
    } vec_t;

    typedef struct {
        int          c;
        logic [15:0] in_ra, w_ra, b_ra, wa;
        logic        set_b;
    } slot_t;

    vec_t  vt[11];
    slot_t got[$];
    slot_t expq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    bit mon_on = 0;
    int done_cyc, busy_first, busy_last, busy_cnt, err_done, err_c1;
    logic [15:0] p_in, p_w, p_b;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Samples outputs on the falling edge; mac_en pairs with the addresses of the previous cycle.
    initial begin
        int mrel;
        slot_t s;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                mrel = cyc - t0;
                if (busy) begin
                    if (busy_first < 0) busy_first = mrel;
                    busy_last = mrel;
                    busy_cnt++;
                end
                if (mac_en) begin
                    s.c = mrel; s.in_ra = p_in; s.w_ra = p_w; s.b_ra = p_b;
                    s.wa = mac_wa; s.set_b = mac_set_b;
                    got.push_back(s);
                end
                if (done && done_cyc < 0) begin
                    done_cyc = mrel;
                    err_done = int'(err);
                end
                if (mrel == 1) err_c1 = int'(err);
            end
            p_in = in_ra; p_w = w_ra; p_b = b_ra;
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic build_exp(input vec_t v);
        int ow, oh, tn, c;
        slot_t s;
        expq.delete();
        if (v.k == 0 || v.k > v.in_w || v.k > v.in_h || v.in_c == 0 || v.out_c == 0) return;
        ow = v.in_w - v.k + 1;
        oh = v.in_h - v.k + 1;
        tn = v.in_c * v.k * v.k;
        c = 2;
        for (int oc = 0; oc < v.out_c; oc++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    for (int t = 0; t <= tn; t++) begin
                        int ic, ky, kx;
                        ic = t / (v.k * v.k);
                        ky = (t / v.k) % v.k;
                        kx = t % v.k;
                        while (v.hold_len > 0 && c >= v.hold_at && c < v.hold_at + v.hold_len) c++;
                        s.c     = c + 1;
                        s.set_b = (t == tn);
                        s.in_ra = 16'(v.in_b + (ic * v.in_h + oy + ky) * v.in_w + ox + kx);
                        s.w_ra  = 16'(v.w_b + ((oc * v.in_c + ic) * v.k + ky) * v.k + kx);
                        s.b_ra  = 16'(v.b_b + oc);
                        s.wa    = 16'(v.o_b + (oc * oh + oy) * ow + ox);
                        expq.push_back(s);
                        c++;
                    end
    endtask

    task automatic drive_cfg(input vec_t v);
        cfg_in_w = 8'(v.in_w); cfg_in_h = 8'(v.in_h); cfg_in_c = 8'(v.in_c);
        cfg_out_c = 8'(v.out_c); cfg_k = 4'(v.k);
        cfg_in_base = 16'(v.in_b); cfg_w_base = 16'(v.w_b);
        cfg_b_base = 16'(v.b_b); cfg_out_base = 16'(v.o_b);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int rel, guard, bad;
        v = vt[i];
        drive_cfg(v);
        build_exp(v);
        got.delete();
        done_cyc = -1; busy_first = -1; busy_last = -1; busy_cnt = 0; err_done = -1; err_c1 = -1;
        @(posedge clk); #1;
        t0 = cyc; mon_on = 1; start = 1; hold = 0;
        guard = 0;
        while (done_cyc < 0 && guard < 3000) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            start = (v.restart_at > 0 && rel == v.restart_at);
            hold = (v.hold_len > 0 && rel >= v.hold_at && rel < v.hold_at + v.hold_len);
            guard++;
        end
        start = 0; hold = 0;
        repeat (4) @(posedge clk);
        #1; mon_on = 0;

        check($sformatf("v%0d_done_cycle", i), done_cyc, v.exp_done);
        check($sformatf("v%0d_err_at_done", i), err_done, v.exp_err);
        check($sformatf("v%0d_err_cleared_by_start", i), err_c1, 0);
        check($sformatf("v%0d_mac_en_count", i), got.size(), v.exp_en);
        check($sformatf("v%0d_model_count", i), got.size(), expq.size());
        check($sformatf("v%0d_busy_first", i), busy_first, 1);
        check($sformatf("v%0d_busy_last", i), busy_last, v.exp_done);
        check($sformatf("v%0d_busy_count", i), busy_cnt, v.exp_done);
        check($sformatf("v%0d_perf_cycles", i), perf_cycles, PERF_ON ? v.exp_done : 0);
        bad = 0;
        for (int j = 0; j < got.size() && j < expq.size(); j++) begin
            if (got[j].c !== expq[j].c || got[j].set_b !== expq[j].set_b ||
                got[j].b_ra !== expq[j].b_ra || got[j].wa !== expq[j].wa ||
                (!expq[j].set_b && (got[j].in_ra !== expq[j].in_ra || got[j].w_ra !== expq[j].w_ra))) begin
                if (bad == 0)
                    $display("[TB] v%0d slot %0d: cyc %0d/%0d in %h/%h w %h/%h b %h/%h wa %h/%h sb %0d/%0d",
                             i, j, got[j].c, expq[j].c, got[j].in_ra, expq[j].in_ra, got[j].w_ra, expq[j].w_ra,
                             got[j].b_ra, expq[j].b_ra, got[j].wa, expq[j].wa, got[j].set_b, expq[j].set_b);
                bad++;
            end
        end
        check($sformatf("v%0d_slot_sequence", i), bad, 0);
        $display("[TB] vec %0d: done@%0d err=%0d mac_en=%0d perf=%0d", i, done_cyc, err_done, got.size(), perf_cycles);
    endtask

    initial begin
        int en_seen;
        //         in_w in_h in_c out_c k  in_b    w_b     b_b     o_b     hold_at len rst  done  en  err
        vt[0]  = '{4, 4, 1, 1, 3, 0,      0,      0,      0,      0, 0, 0,  46,  40, 0};
        vt[1]  = '{3, 3, 2, 2, 2, 0,      'h100,  'h200,  0,      0, 0, 0,  78,  72, 0};
        vt[2]  = '{4, 4, 1, 1, 3, 0,      0,      0,      0,      5, 3, 0,  49,  40, 0};
        vt[3]  = '{4, 4, 1, 1, 5, 0,      0,      0,      0,      0, 0, 0,  2,   0,  1};
        vt[4]  = '{2, 2, 1, 1, 1, 'h10,   'h20,   'h30,   'h40,   0, 0, 0,  14,  8,  0};
        vt[5]  = '{4, 4, 0, 1, 3, 0,      0,      0,      0,      0, 0, 0,  2,   0,  1};
        vt[6]  = '{5, 4, 1, 3, 2, 'hFFF0, 'hFFFC, 'hFFFF, 'hFFFE, 0, 0, 0,  186, 180, 0};
        vt[7]  = '{4, 4, 1, 1, 3, 0,      0,      0,      0,      0, 0, 10, 46,  40, 0};
        vt[8]  = '{3, 3, 1, 0, 2, 0,      0,      0,      0,      0, 0, 0,  2,   0,  1};
        vt[9]  = '{4, 2, 1, 1, 3, 0,      0,      0,      0,      0, 0, 0,  2,   0,  1};
        vt[10] = '{4, 4, 1, 1, 0, 0,      0,      0,      0,      0, 0, 0,  2,   0,  1};

        rst = 1; start = 1; hold = 0;
        drive_cfg(vt[4]);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {in_ra, w_ra, b_ra, mac_en, mac_set_b, mac_wa, busy, done, err, perf_cycles}, 0);
        start = 0;
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 11; i++) run_vec(i);

        // Reset in the middle of a basic run, then confirm the run reproduces from scratch.
        drive_cfg(vt[0]);
        @(posedge clk); #1;
        t0 = cyc; start = 1;
        while (cyc - t0 < 20) begin
            @(posedge clk); #1;
            start = 0;
        end
        check("pre_reset_busy", busy, 1);
        rst = 1;
        #1;
        check("mid_reset_outputs", {in_ra, w_ra, b_ra, mac_en, mac_set_b, mac_wa, busy, done, err, perf_cycles}, 0);
        en_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (mac_en || busy) en_seen++;
        end
        check("reset_quiet", en_seen, 0);
        @(posedge clk); #1;
        rst = 0;
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_seq.md
# conv_seq

Sequencer for the convolution MAC datapath. From a run-time layer descriptor it walks every output pixel of a stride-1, no-padding convolution. For each pixel it issues input, weight and bias read addresses to the synchronous feature, weight and bias memories. It drives the MAC unit's `en`, `set_b` and write-address inputs in alignment with the returned read data. It sits between the layer-level control FSM and one MAC unit, and signals completion once the last result has been written.

## Interface
Parameters:
- `DATA_SIZE`, 16: datapath width; unused internally, kept for uniform instantiation.
- `MEM_SIZE`, 16: address width of all memories.
- `DIM_W`, 8: width of the dimension fields.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle launch request; ignored unless the block is idle.
- `hold` in 1: memory-port stall. While high, the block freezes.
- `cfg_in_w`, `cfg_in_h`, `cfg_in_c`, `cfg_out_c` in DIM_W: input width, input height, input channels, output channels.
- `cfg_k` in 4: kernel size K.
- `cfg_in_base`, `cfg_w_base`, `cfg_b_base`, `cfg_out_base` in MEM_SIZE: region base addresses.
- `in_ra`, `w_ra`, `b_ra` out MEM_SIZE: read addresses.
- `mac_en`, `mac_set_b` out 1: MAC enable and bias/close-pixel strobe.
- `mac_wa` out MEM_SIZE: output write address presented to the MAC.
- `busy` out 1: high from launch until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: set with `done` when the descriptor is illegal; cleared on the next `start`.
- `perf_cycles` out 32: see Configuration.

## Operation
- States:
  - IDLE: waits for `start`.
  - CHECK: one cycle. Validates the descriptor.
  - RUN: issues addresses.
  - DRAIN: waits for the MAC pipeline to empty.
  - DONE: one cycle, `done`=1, then returns to IDLE.
- CHECK rules:
  - The descriptor is illegal if K=0, K>in_w, K>in_h, in_c=0 or out_c=0.
  - Illegal: go to DONE with `err`=1. No `mac_en` is issued.
  - Legal: go to RUN.
- Derived values:
  - OW = in_w−K+1, OH = in_h−K+1.
  - Terms per pixel T = in_c·K·K.
- Loop order, outer to inner: oc, oy, ox, then ic, ky, kx.
- Each pixel takes T+1 issue slots:
  - T product slots: `set_b`=0.
  - 1 bias slot: `set_b`=1.
  - `b_ra` is valid in every slot.
  - `in_ra` and `w_ra` are don't-care in the bias slot.
- Address equations, all modulo 2^MEM_SIZE:
  - `in_ra` = in_base + (ic·in_h + oy+ky)·in_w + ox+kx
  - `w_ra` = w_base + ((oc·in_c+ic)·K+ky)·K+kx
  - `b_ra` = b_base + oc
  - `mac_wa` = out_base + (oc·OH+oy)·OW+ox, constant over all slots of a pixel.
- The address equations may be realised with incremental pointers. Results must be bit-identical.
- `hold`=1 in RUN:
  - Counters and addresses are frozen.
  - The slot is not issued, so `mac_en` is 0 one cycle later.
  - Issue resumes on the first cycle with `hold`=0.
- DRAIN: exactly 3 cycles after the final bias slot's `mac_en`, then DONE.
- `start` while busy: ignored.
- `rst` mid-operation: all state and outputs return to their reset values immediately. No further `mac_en` is issued.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `start` sampled high in cycle 0: CHECK in cycle 1, first address in cycle 2.
- Memories have 1-cycle read latency. `mac_en`, `mac_set_b` and `mac_wa` are registered and lag the matching read address by exactly 1 cycle, aligned with the read data.
- Without `hold`: a pixel occupies T+1 consecutive cycles, with no bubbles between pixels or output channels.
- The last MAC write lands 3 cycles after the last `mac_en`. `done` is asserted in the cycle after DRAIN completes.
- `busy`=1 from cycle 1 through the `done` cycle inclusive.

## Configuration
- `CONV_SEQ_PERF_EN` defined:
  - `perf_cycles` counts the cycles with `busy`=1 of the current or most recent run.
  - It clears on launch and holds its value after `done`.
  - It is 0 on reset.
- Not defined: `perf_cycles` is tied to 0 and no counter logic is built.

## Test plan
- **Basic run.** in 4×4×1, K=3, out_c=1, all bases 0, `start` at cycle 0.
  - 40 `mac_en` cycles, cycles 3–42.
  - `mac_set_b` at cycles 12, 22, 32 and 42.
  - `mac_wa` sequence 0, 1, 2, 3.
  - `done` at cycle 46; `busy` high in cycles 1–46.
- **Multi-channel.** in 3×3×2, K=2, out_c=2, `w_base`=0x100, `b_base`=0x200.
  - First pixel `w_ra` = 0x100–0x107.
  - oc=1 uses `b_ra`=0x201 and `w_ra` 0x108–0x10F.
  - 8 pixels × 9 slots = 72 `mac_en`.
- **Hold.** Basic run with `hold` high for cycles 5–7.
  - `mac_en` is low in cycles 6–8 and the address sequence is unchanged.
  - `done` slips by 3 cycles, to cycle 49.
- **Illegal descriptor.** K=5 with in_w=4.
  - `done` and `err` are high in cycle 2; no `mac_en` is issued.
  - The next legal `start` clears `err`.
- **Reset mid-run.** Assert `rst` at cycle 20.
  - All outputs are 0 immediately.
  - A new `start` afterwards reproduces the basic run exactly.
- **Perf counter.** With `CONV_SEQ_PERF_EN`, after the basic run `perf_cycles`=46.
  - A `start` pulse while `busy` is ignored.
